// File: rtl/dp_sequencer.sv
// dp_sequencer
//
// Sequences a dot-product job over an external multiply-accumulate datapath.
// Operand pairs are loaded into a small buffer. A start request then feeds
// them to the datapath one element at a time. When the last element is done,
// the datapath's captured result is read back. The datapath accumulator is
// never cleared, so the previous captured value (base) is subtracted from it.
//
// Ports
//   ACLK, ARESETN          clock (rising edge) and async active-low reset
//   wr_en, wr_addr         operand buffer write strobe / index (dropped while busy)
//   wr_a, wr_b             operand pair written at wr_addr
//   cfg_len                vector length, clamped to DEPTH
//   start                  single-cycle job request (ignored while busy)
//   busy, done, err        job in progress / one-cycle completion pulse / sticky timeout
//   result                 dot product of the last successful job
//   dp_a, dp_b             operands to the datapath, held outside ISSUE
//   inputs_ready           element strobe, high for exactly the ISSUE cycle
//   dp_start               result-capture enable, high across the last element
//   dp_result, dp_done     datapath captured result / per-element completion pulse
//
// The datapath must share ARESETN so that base stays aligned with its accumulator.
// TIMEOUT is expected to be at least 2.

module dp_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW = $clog2(DEPTH + 1),
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_a,
    input  logic [7:0]    wr_b,
    input  logic [LW-1:0] cfg_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   result,
    output logic [7:0]    dp_a,
    output logic [7:0]    dp_b,
    output logic          inputs_ready,
    output logic          dp_start,
    input  logic [31:0]   dp_result,
    input  logic          dp_done
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   base_q, base_d;
    logic [7:0]    dp_a_q, dp_a_d;
    logic [7:0]    dp_b_q, dp_b_d;
    logic          ir_q, ir_d;
    logic          dps_q, dps_d;

    logic [LW-1:0] len_clamped;
    logic          issue;
    logic          got_done;
    logic          wait_last;
    logic [15:0]   rd_word;

    assign len_clamped = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
    assign wait_last   = ((LW'(idx_q) + LW'(1)) == len_q);
    // A dp_done pulse in the first WAIT cycle is remembered so the element
    // cadence never drops below ISSUE, WAIT, WAIT.
    assign got_done    = dp_done | seen_q;

    // Buffer writes are only accepted while idle.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && !busy_q) begin
            mem_d[wr_addr] = {wr_a, wr_b};
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        base_d   = base_q;
        dp_a_d   = dp_a_q;
        dp_b_d   = dp_b_q;
        ir_d     = 1'b0;
        dps_d    = dps_q;
        issue    = 1'b0;
        rd_word  = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d = len_clamped;
                    idx_d = '0;
                    err_d = 1'b0;
                    if (len_clamped == '0) begin
                        result_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StIssue;
                        issue   = 1'b1;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                seen_d  = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                if (got_done && (cnt_q != '0)) begin
                    if (wait_last) begin
                        dps_d   = 1'b0;
                        state_d = StCapture;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = StIssue;
                        issue   = 1'b1;
                    end
                end else if (!got_done && (cnt_q == CW'(TIMEOUT - 1))) begin
                    // Timed out: report it but keep result and base untouched.
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    dps_d   = 1'b0;
                    state_d = StIdle;
                end else begin
                    seen_d = got_done;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            StCapture: begin
                result_d = dp_result - base_q;
                base_d   = dp_result;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs for ISSUE are registered on entry so they line up with the state.
        // Reading mem_d forwards a write made in the same cycle as start.
        if (issue) begin
            rd_word = mem_d[idx_d];
            dp_a_d  = rd_word[15:8];
            dp_b_d  = rd_word[7:0];
            ir_d    = 1'b1;
            dps_d   = ((LW'(idx_d) + LW'(1)) == len_d);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= StIdle;
            len_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            base_q   <= '0;
            dp_a_q   <= '0;
            dp_b_q   <= '0;
            ir_q     <= 1'b0;
            dps_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            base_q   <= base_d;
            dp_a_q   <= dp_a_d;
            dp_b_q   <= dp_b_d;
            ir_q     <= ir_d;
            dps_q    <= dps_d;
            mem_q    <= mem_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign result       = result_q;
    assign dp_a         = dp_a_q;
    assign dp_b         = dp_b_q;
    assign inputs_ready = ir_q;
    assign dp_start     = dps_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Testbench for dp_sequencer with a non-clearing MAC datapath model.

module tb_dp_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 15;

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b0;
    logic        wr_en   = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_a    = '0;
    logic [7:0]  wr_b    = '0;
    logic [4:0]  cfg_len = '0;
    logic        start   = 1'b0;
    logic        busy, done, err;
    logic [31:0] result;
    logic [7:0]  dp_a, dp_b;
    logic        inputs_ready, dp_start;
    logic [31:0] dp_result;
    logic        dp_done;

    int checks   = 0;
    int failures = 0;

    // Datapath model controls
    int dly   = 2;
    bit dd_en = 1'b1;

    logic [31:0] acc;
    int          pend;

    // Monitor state, written only by the monitor
    int          ir_cnt   = 0;
    int          done_cnt = 0;
    logic [15:0] ds_hist  = '0;

    always #5 ACLK = ~ACLK;

    dp_sequencer #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TMO)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_a        (wr_a),
        .wr_b        (wr_b),
        .cfg_len     (cfg_len),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .result      (result),
        .dp_a        (dp_a),
        .dp_b        (dp_b),
        .inputs_ready(inputs_ready),
        .dp_start    (dp_start),
        .dp_result   (dp_result),
        .dp_done     (dp_done)
    );

    // Accumulates a*b on each strobe, captures when dp_start is set, and
    // pulses dp_done dly cycles later (dly=0: in the first WAIT cycle).
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            acc       <= '0;
            dp_result <= '0;
            dp_done   <= 1'b0;
            pend      <= 0;
        end else begin
            dp_done <= 1'b0;
            if (inputs_ready) begin
                acc <= acc + 32'(dp_a) * 32'(dp_b);
                if (dp_start) dp_result <= acc + 32'(dp_a) * 32'(dp_b);
                if (dd_en) begin
                    if (dly == 0) dp_done <= 1'b1;
                    else pend <= dly;
                end
            end else if (pend != 0) begin
                if (pend == 1) dp_done <= 1'b1;
                pend <= pend - 1;
            end
        end
    end

    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (inputs_ready) begin
                ir_cnt  <= ir_cnt + 1;
                ds_hist <= {ds_hist[14:0], dp_start};
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] x, input logic [7:0] y);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_a    = x;
        wr_b    = y;
        @(negedge ACLK);
        wr_en = 1'b0;
    endtask

    task automatic kick(input logic [4:0] l);
        cfg_len = l;
        start   = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                n = i;
                break;
            end
            @(negedge ACLK);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, err, inputs_ready, dp_start} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {busy, done, err, inputs_ready, dp_start});
        end
        checks++;
        if ({result, dp_a, dp_b} !== 48'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {result, dp_a, dp_b});
        end
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({busy, done, err, inputs_ready} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b want=0000", {busy, done, err, inputs_ready});
        end
    endtask

    task automatic test_basic;
        int n, ir0, dn0;
        ir0 = ir_cnt;
        dn0 = done_cnt;
        dly = 2;
        wr(4'd0, 8'd1, 8'd4);
        wr(4'd1, 8'd2, 8'd5);
        wr(4'd2, 8'd3, 8'd6);
        kick(5'd3);
        wait_done(n);
        checks++;
        if (n < 0) begin failures++; $display("FAIL basic_wait got=timeout want=done"); end
        checks++;
        if (result !== 32'd32) begin failures++; $display("FAIL basic_result got=%0d want=32", result); end
        checks++;
        if ({busy, err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b want=00", {busy, err}); end
        repeat (4) @(negedge ACLK);
        checks++;
        if (ir_cnt - ir0 != 3) begin failures++; $display("FAIL basic_strobes got=%0d want=3", ir_cnt - ir0); end
        checks++;
        if (ds_hist[2:0] !== 3'b001) begin failures++; $display("FAIL basic_dp_start got=%b want=001", ds_hist[2:0]); end
        checks++;
        if (done_cnt - dn0 != 1) begin failures++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt - dn0); end
        checks++;
        if ({dp_a, dp_b} !== {8'd3, 8'd6}) begin failures++; $display("FAIL basic_hold got=%h want=0306", {dp_a, dp_b}); end
    endtask

    task automatic test_second;
        int n, ir0;
        ir0 = ir_cnt;
        dly = 1;
        // Write and start in the same cycle: the job must see the new pair.
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_a    = 8'd2;
        wr_b    = 8'd3;
        cfg_len = 5'd1;
        start   = 1'b1;
        @(negedge ACLK);
        wr_en = 1'b0;
        start = 1'b0;
        wait_done(n);
        checks++;
        if (n < 0 || result !== 32'd6) begin failures++; $display("FAIL second_result got=%0d n=%0d want=6", result, n); end
        checks++;
        if (dut.base_q !== 32'd38) begin failures++; $display("FAIL second_base got=%0d want=38", dut.base_q); end
        checks++;
        if (ir_cnt - ir0 != 1 || ds_hist[0] !== 1'b1) begin
            failures++;
            $display("FAIL second_strobes got=%0d/%b want=1/1", ir_cnt - ir0, ds_hist[0]);
        end
        // A write while busy must be dropped; the rerun still computes 2*3.
        @(negedge ACLK);
        kick(5'd1);
        wr(4'd0, 8'd9, 8'd9);
        wait_done(n);
        checks++;
        if (n < 0 || result !== 32'd6) begin failures++; $display("FAIL busy_write got=%0d n=%0d want=6", result, n); end
    endtask

    task automatic test_full;
        int n, ir0;
        dly = 0;
        for (int i = 0; i < 16; i++) wr(4'(i), 8'd255, 8'd255);
        ir0 = ir_cnt;
        kick(5'd16);
        wait_done(n);
        checks++;
        if (n < 0 || result !== 32'd1040400) begin failures++; $display("FAIL full_result got=%0d n=%0d want=1040400", result, n); end
        @(negedge ACLK);
        checks++;
        if (ir_cnt - ir0 != 16 || ds_hist !== 16'h0001) begin
            failures++;
            $display("FAIL full_strobes got=%0d/%h want=16/0001", ir_cnt - ir0, ds_hist);
        end
        ir0 = ir_cnt;
        kick(5'd20);
        wait_done(n);
        checks++;
        if (n < 0 || result !== 32'd1040400) begin failures++; $display("FAIL clamp_result got=%0d n=%0d want=1040400", result, n); end
        @(negedge ACLK);
        checks++;
        if (ir_cnt - ir0 != 16) begin failures++; $display("FAIL clamp_strobes got=%0d want=16", ir_cnt - ir0); end
    endtask

    task automatic test_timeout;
        int n, ir0;
        ir0   = ir_cnt;
        dd_en = 1'b0;
        kick(5'd1);
        wait_done(n);
        checks++;
        if (n != int'(TMO) + 1) begin failures++; $display("FAIL tmo_latency got=%0d want=%0d", n, TMO + 1); end
        checks++;
        if ({err, busy} !== 2'b10) begin failures++; $display("FAIL tmo_flags got=%b want=10", {err, busy}); end
        checks++;
        if (result !== 32'd1040400) begin failures++; $display("FAIL tmo_result got=%0d want=1040400", result); end
        repeat (3) @(negedge ACLK);
        checks++;
        if (err !== 1'b1 || ir_cnt - ir0 != 1) begin
            failures++;
            $display("FAIL tmo_sticky got=%b/%0d want=1/1", err, ir_cnt - ir0);
        end
        dd_en = 1'b1;
    endtask

    task automatic test_zero;
        int n, ir0;
        ir0 = ir_cnt;
        kick(5'd0);
        wait_done(n);
        checks++;
        if (n != 0) begin failures++; $display("FAIL zero_latency got=%0d want=0", n); end
        checks++;
        if ({err, busy} !== 2'b00 || result !== 32'd0) begin
            failures++;
            $display("FAIL zero_state got=%b/%0d want=00/0", {err, busy}, result);
        end
        repeat (3) @(negedge ACLK);
        checks++;
        if (ir_cnt - ir0 != 0) begin failures++; $display("FAIL zero_strobes got=%0d want=0", ir_cnt - ir0); end
    endtask

    task automatic test_reset_mid;
        int n, ir0, dn0, k;
        dly = 3;
        wr(4'd0, 8'd1, 8'd4);
        wr(4'd1, 8'd2, 8'd5);
        wr(4'd2, 8'd3, 8'd6);
        ir0 = ir_cnt;
        kick(5'd3);
        k = 0;
        while (ir_cnt - ir0 < 2 && k < 100) begin
            @(negedge ACLK);
            k++;
        end
        checks++;
        if (ir_cnt - ir0 != 2) begin failures++; $display("FAIL mid_reach got=%0d want=2", ir_cnt - ir0); end
        dn0 = done_cnt;
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, inputs_ready, dp_start} !== 5'b0 || {result, dp_a, dp_b} !== 48'h0) begin
            failures++;
            $display("FAIL mid_reset_outs got=%b/%h want=0/0", {busy, done, err, inputs_ready, dp_start},
                     {result, dp_a, dp_b});
        end
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);
        checks++;
        if (done_cnt != dn0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_done got=%0d/%b want=%0d/0", done_cnt, busy, dn0);
        end
        wr(4'd0, 8'd1, 8'd4);
        wr(4'd1, 8'd2, 8'd5);
        wr(4'd2, 8'd3, 8'd6);
        kick(5'd3);
        wait_done(n);
        checks++;
        if (n < 0 || result !== 32'd32) begin failures++; $display("FAIL mid_rerun got=%0d n=%0d want=32", result, n); end
        checks++;
        if (dut.base_q !== 32'd32) begin failures++; $display("FAIL mid_base got=%0d want=32", dut.base_q); end
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        test_reset;
        test_basic;
        @(negedge ACLK);
        test_second;
        @(negedge ACLK);
        test_full;
        @(negedge ACLK);
        test_timeout;
        test_zero;
        @(negedge ACLK);
        test_reset_mid;
        repeat (2) @(negedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
